// File: rtl/vred_logic_seq.sv
// Sequencer for the vredand/vredor/vredxor reductions: accumulates masked beats
// lane-wise, tree-folds the lanes, combines with the scalar seed and hands off one result.
module vred_logic_seq #(
  parameter  int LANES     = 4,
  parameter  int ELEM_W    = 32,
  localparam int LOG_LANES = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op_sel,
  input  logic [ELEM_W-1:0]         scalar_in,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ELEM_W-1:0]   in_data,
  input  logic [LANES-1:0]          in_mask,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELEM_W-1:0]         out_data
);

  localparam int CNT_W = $clog2(LOG_LANES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FOLD  = 3'd2,
    COMB  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ELEM_W-1:0]     r_acc [LANES];
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic [ELEM_W-1:0]     r_scalar;
  logic [ELEM_W-1:0]     r_out_data;
  logic [LOG_LANES-1:0]  w_half;
  logic [ELEM_W-1:0]     w_fold [LANES/2];

  function automatic logic [ELEM_W-1:0] ident_f(input logic [1:0] op);
    case (op)
      2'b01:   return '1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [ELEM_W-1:0] op_f(input logic [1:0] op,
                                             input logic [ELEM_W-1:0] a,
                                             input logic [ELEM_W-1:0] b);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a | b;
      2'b11:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Fold stage: lanes below half combine with their partner half a width away;
  // lanes between half and LANES/2 also get written but are don't-care afterwards.
  always_comb begin
    w_half = LOG_LANES'(1) << (r_cnt - CNT_W'(1));
    for (int i = 0; i < LANES/2; i++) begin
      w_fold[i] = op_f(r_op, r_acc[i], r_acc[LOG_LANES'(i) + w_half]);
    end
  end

  // Command sequencing, accumulation, folding and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= 2'b00;
      r_scalar   <= '0;
      r_out_data <= '0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op     <= op_sel;
            r_scalar <= scalar_in;
            for (int i = 0; i < LANES; i++) r_acc[i] <= ident_f(op_sel);
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
              r_acc[i] <= op_f(r_op, r_acc[i],
                               in_mask[i] ? in_data[i*ELEM_W +: ELEM_W] : ident_f(r_op));
            end
            if (in_last) begin
              r_cnt   <= CNT_W'(LOG_LANES);
              r_state <= FOLD;
            end
          end
        end
        FOLD: begin
          // Stages run while the counter is non-zero; the zero cycle hands over to COMB.
          if (r_cnt != '0) begin
            for (int i = 0; i < LANES/2; i++) r_acc[i] <= w_fold[i];
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= COMB;
          end
        end
        COMB: begin
          r_out_data <= op_f(r_op, r_acc[0], r_scalar);
          r_state    <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_vred_logic_seq.sv
// Directed self-checking bench for vred_logic_seq (LANES=4, ELEM_W=32).
module tb_vred_logic_seq;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op_sel;
  logic [31:0]   scalar_in;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [3:0]    in_mask;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;

  int checks = 0;
  int errors = 0;
  int lat;

  vred_logic_seq #(.LANES(4), .ELEM_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .scalar_in(scalar_in),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [31:0] sc);
    start = 1'b1; op_sel = op; scalar_in = sc;
    tick();
    start = 1'b0; op_sel = 2'b00; scalar_in = 32'h0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [3:0] m, input logic l);
    in_valid = 1'b1; in_data = d; in_mask = m; in_last = l;
    chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_data = {4{32'hDEADBEEF}}; in_mask = 4'b0000; in_last = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_cmd(input string tag, input logic [31:0] exp);
    int n;
    wait_valid(n);
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sel = 2'b00; scalar_in = 32'h0;
    in_valid = 1'b0; in_data = '0; in_mask = 4'b0000; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);

    // XOR: 1^2^4^8 = 0xF, ^0xFF = 0xF0
    start_cmd(2'b11, 32'h000000FF);
    send_beat({32'd8, 32'd4, 32'd2, 32'd1}, 4'b1111, 1'b1);
    finish_cmd("xor_basic", 32'h000000F0);

    // AND with lane 1 masked off
    start_cmd(2'b01, 32'hFFFFFFFF);
    send_beat({32'hFF00FF00, 32'hFFFF0000, 32'h00000000, 32'hF0F0F0F0}, 4'b1101, 1'b1);
    finish_cmd("and_mask", 32'hF0000000);

    // OR over three beats with idle gaps
    start_cmd(2'b10, 32'h0);
    send_beat({96'h0, 32'h00000001}, 4'b1111, 1'b0);
    for (int g = 0; g < 2; g++) begin
      tick();
      chk("or_gap_ready", {31'd0, in_ready}, 32'd1);
    end
    send_beat({96'h0, 32'h00000100}, 4'b1111, 1'b0);
    for (int g = 0; g < 2; g++) begin
      tick();
      chk("or_gap_ready", {31'd0, in_ready}, 32'd1);
    end
    send_beat({96'h0, 32'h00010000}, 4'b1111, 1'b1);
    finish_cmd("or_gaps", 32'h00010101);

    // DONE stall with ignored start pulses
    start_cmd(2'b11, 32'h0);
    send_beat({32'h0, 32'h0, 32'h22, 32'h11}, 4'b0011, 1'b1);
    wait_valid(lat);
    chk("stall_latency", lat, 32'd4);
    for (int s = 0; s < 5; s++) begin
      start = 1'b1; op_sel = 2'b01; scalar_in = 32'hFFFFFFFF;
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'h00000033);
    end
    start = 1'b0; op_sel = 2'b00; scalar_in = 32'h0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_busy_low", {31'd0, busy}, 32'd0);
    chk("stall_valid_low", {31'd0, out_valid}, 32'd0);

    // op 00 always yields zero
    start_cmd(2'b00, 32'hABCDEF01);
    send_beat({32'h1, 32'h2, 32'h3, 32'h4}, 4'b1111, 1'b1);
    finish_cmd("op_zero", 32'h0);

    // AND, everything masked: result is the seed
    start_cmd(2'b01, 32'h12345678);
    send_beat({32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 1'b0);
    send_beat({32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 1'b1);
    finish_cmd("and_all_masked", 32'h12345678);

    // Reset in the middle of ACCUM
    start_cmd(2'b11, 32'h0000FFFF);
    send_beat({4{32'hFFFFFFFF}}, 4'b1111, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    start_cmd(2'b11, 32'h0);
    send_beat({32'h0, 32'h0, 32'h0, 32'h3}, 4'b1111, 1'b1);
    finish_cmd("after_rst", 32'h00000003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vred_logic_seq.md
Name: vred_logic_seq

Overview:
- Sequencer for the integer logical reductions vredand, vredor and vredxor.
- Accepts a reduction command (op, scalar seed vs1[0]) and a stream of masked vector beats from the VRF read path.
- Folds each beat into a lane-wide accumulator, then tree-folds the lanes, combines the result with the scalar seed, and presents one scalar result with a valid/ready handshake.
- Sits between the vALU issue logic and the writeback of vd[0].

Parameters:
- LANES, 4, elements per beat; power of two, at least 2.
- ELEM_W, 32, element width in bits.
- LOG_LANES, $clog2(LANES), number of fold stages; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- op_sel  in  2  operation: 01=and, 10=or, 11=xor, 00=zero result
- scalar_in  in  ELEM_W  seed value vs1[0]; captured on start
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept; high only in ACCUM
- in_data  in  LANES*ELEM_W  beat data; lane i = bits [i*ELEM_W +: ELEM_W]
- in_mask  in  LANES  per-lane active bit; lane i = bit i
- in_last  in  1  final beat of the command
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_data  out  ELEM_W  reduction result

Behaviour:
- States: IDLE, ACCUM, FOLD, COMB, DONE.
- Reset: state=IDLE, accumulator=0, fold counter=0, captured op and scalar=0, out_data=0. All outputs low.
- Reset applies from any state, including mid-command; the partial result is discarded.
- Identity value: all-ones for AND; zero for OR, XOR and op 00.
- IDLE:
  - start=1 captures op_sel and scalar_in.
  - Each accumulator lane is loaded with the identity value.
  - Next state is ACCUM. in_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready, each lane becomes acc[i] op (in_mask[i] ? in_data lane i : identity).
  - If in_last is set on that handshake, the fold counter is loaded with LOG_LANES and the next state is FOLD.
  - Cycles with in_valid=0 hold all state; there is no timeout.
- FOLD:
  - One stage per cycle. With active width w (starting at LANES), lanes [0, w/2) become lane[i] op lane[i+w/2]; w then halves.
  - Lanes at or above the new width are don't-care.
  - The counter decrements each cycle; after LOG_LANES cycles the next state is COMB.
- COMB:
  - out_data <= lane0 op captured scalar; for op 00, out_data <= 0.
  - Next state is DONE.
- DONE:
  - out_valid=1; out_data is held stable until the handshake.
  - On out_ready, next state is IDLE and out_valid drops next cycle.
- Latency: out_valid rises LOG_LANES+2 cycles after the edge that accepts the last beat (4 cycles for LANES=4).
- start is ignored while busy; it is not queued.
- A new start is accepted in the cycle after DONE exits, giving 1 cycle of minimum IDLE.
- All-masked beats leave the accumulator unchanged. If every lane of every beat is masked, the result is identity op scalar, i.e. the scalar itself for AND, OR and XOR.
- All registers are bitwise; there are no carries and no sign handling.
- op_sel changes after start have no effect until the next command.

Test Plan:
- XOR, LANES=4, ELEM_W=32, scalar 0x000000FF, one beat {1,2,4,8}, mask 1111, last=1 -> out_data 0x000000F0; out_valid exactly 4 cycles after beat accept.
- AND, scalar 0xFFFFFFFF, beat {0xF0F0F0F0, 0x00000000, 0xFFFF0000, 0xFF00FF00}, mask 1101 -> out_data 0xF0000000 (masked lane 1 zero ignored).
- OR, scalar 0, three beats with 2-cycle in_valid gaps, lane 0 = 0x1, 0x100, 0x10000 and other lanes zero, last on beat 3 -> out_data 0x00010101; in_ready stays high through the gaps; busy high from the cycle after start.
- out_ready held low 5 cycles in DONE -> out_valid and out_data stable throughout; start pulses during that window ignored; after out_ready=1, busy=0 next cycle and a fresh command is then accepted.
- rst=1 for one cycle mid-ACCUM after 1 beat -> next cycle busy=0, in_ready=0, out_valid=0; the following XOR command with one beat {3,0,0,0} and scalar 0 yields 0x00000003 (no residue).
- Edge cases: op_sel=00 with any data -> out_data 0. AND with all lanes masked and scalar 0x12345678 -> out_data 0x12345678.
